rx_frame_ctrl: RTL and testbench

- Parametrised receive-frame controller between the symbol decoder (sym_dec) and host logic; replaces single-buffer event handling in the RX path.
- Converts decoder event strobes into buffer writes and a queued event stream with valid/ready flow control.
- Manages a ping-pong pair of frame banks, checks frame length and inter-event timeout, and aborts/resets the decoder on error.

---
 rtl/rx_frame_pkg.sv | 42 ++++
 rtl/rx_frame_ctrl_ev_fifo.sv | 55 +++++
 rtl/rx_frame_ctrl.sv | 270 +++++++++++++++++++++++++++
 tb/tb_rx_frame_ctrl.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rx_frame_pkg.sv
`default_nettype none
// ============================================================================
// rx_frame_pkg : shared event, cause and state codes for the RX frame path
// Rev 1.0
// ============================================================================
package rx_frame_pkg;

    localparam logic [2:0] DEC_EV_NONE     = 3'd0;
    localparam logic [2:0] DEC_EV_PREAMBLE = 3'd1;
    localparam logic [2:0] DEC_EV_SFD      = 3'd2;
    localparam logic [2:0] DEC_EV_PHR      = 3'd3;
    localparam logic [2:0] DEC_EV_BYTE     = 3'd4;
    localparam logic [2:0] DEC_EV_COMPLETE = 3'd5;

    localparam logic [2:0] RX_EV_NONE      = 3'd0;
    localparam logic [2:0] RX_EV_PREAMBLE  = 3'd1;
    localparam logic [2:0] RX_EV_SFD       = 3'd2;
    localparam logic [2:0] RX_EV_PHR       = 3'd3;
    localparam logic [2:0] RX_EV_BYTE      = 3'd4;
    localparam logic [2:0] RX_EV_END       = 3'd5;
    localparam logic [2:0] RX_EV_ERROR     = 3'd6;

    localparam logic [1:0] CAUSE_NOBUF     = 2'd0;
    localparam logic [1:0] CAUSE_LEN       = 2'd1;
    localparam logic [1:0] CAUSE_SHORT     = 2'd2;
    localparam logic [1:0] CAUSE_TIMEOUT   = 2'd3;

    localparam int STATE_W = 2;
    localparam logic [STATE_W-1:0] ST_IDLE    = 2'd0;
    localparam logic [STATE_W-1:0] ST_HUNT    = 2'd1;
    localparam logic [STATE_W-1:0] ST_HDR     = 2'd2;
    localparam logic [STATE_W-1:0] ST_PAYLOAD = 2'd3;

    localparam int EVQ_W = 5;

    // Queue entry layout: cause in the upper bits, event code in the lower bits.
    function automatic logic [EVQ_W-1:0] pack_ev(input logic [2:0] ev, input logic [1:0] cause);
        return {cause, ev};
    endfunction

endpackage
`default_nettype wire

// File: rtl/rx_frame_ctrl_ev_fifo.sv
`default_nettype none
// ============================================================================
// ev_fifo : event queue with valid/ready pop, drop-on-full push, sync flush
// Rev 1.0
// ============================================================================
module ev_fifo #(
    parameter int WIDTH = 5,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop_ready,
    output logic [WIDTH-1:0] head_data,
    output logic             head_valid,
    output logic             overflow
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W:0]   count;
    logic             full;
    logic             do_pop;
    logic             do_push;

    assign full       = (count == (PTR_W+1)'(DEPTH));
    assign head_valid = (count != '0);
    assign do_pop     = pop_ready && head_valid;
    // A pop in the same cycle frees the slot, so a push at full is still taken.
    assign do_push    = push && (!full || do_pop);
    assign overflow   = push && full && !do_pop;
    assign head_data  = head_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= push_data;
    end

endmodule
`default_nettype wire

// File: rtl/rx_frame_ctrl.sv
`default_nettype none
// ============================================================================
// rx_frame_ctrl : turns decoder strobes into ping-pong bank writes and a
// queued host event stream, with length/timeout checking and decoder abort.
// Rev 1.0
// ============================================================================
module rx_frame_ctrl
    import rx_frame_pkg::*;
#(
    parameter int ADDR_W      = 7,
    parameter int EVQ_DEPTH   = 8,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_enable,
    input  logic [2:0]        i_dec_ev,
    input  logic              i_dec_ev_sig,
    input  logic [7:0]        i_dec_byte,
    input  logic              i_dec_fcs_ok,
    output logic              o_dec_reset,
    output logic              o_buf_w_en,
    output logic [ADDR_W:0]   o_buf_w_addr,
    output logic [7:0]        o_buf_w_byte,
    output logic [2:0]        o_ev,
    output logic [1:0]        o_ev_cause,
    output logic              o_ev_valid,
    input  logic              i_ev_ready,
    output logic              o_ev_lost,
    output logic              o_rdy,
    output logic              o_rdy_bank,
    output logic [7:0]        o_rdy_len,
    output logic              o_rdy_fcs_ok,
    input  logic              i_release,
    output logic              o_sfd,
    output logic              o_active
);
    localparam int CNT_W = (ADDR_W > 8) ? ADDR_W : 8;
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] MAX_LEN = CNT_W'((1 << ADDR_W) - 1);

    logic [STATE_W-1:0] state, next_state;
    logic               in_frame, strobe, tmo_fire;
    logic [TMO_W-1:0]   tmo_cnt;
    logic [CNT_W-1:0]   len_r, cnt, cnt_inc, len_ext;
    logic               len_bad;

    logic               claimed, cur_bank, first;
    logic [1:0]         done, bank_free, bank_fcs;
    logic [7:0]         bank_len [2];
    logic               have_free, free_bank, rel;

    logic               push, wr_en, claim, finish, abort, nobuf, load_len, step_cnt;
    logic [2:0]         push_ev;
    logic [1:0]         push_cause;
    logic [ADDR_W-1:0]  wr_off;
    logic [EVQ_W-1:0]   head;
    logic               overflow;

    logic               dec_rst, active, lost, buf_w_en;
    logic [ADDR_W:0]    buf_w_addr;
    logic [7:0]         buf_w_byte;

    assign strobe    = i_dec_ev_sig;
    assign in_frame  = (state == ST_HDR) || (state == ST_PAYLOAD);
    assign tmo_fire  = in_frame && !strobe && (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));
    assign cnt_inc   = cnt + 1'b1;
    assign len_ext   = CNT_W'(i_dec_byte);
    assign len_bad   = (len_ext == '0) || (len_ext > MAX_LEN);

    assign bank_free[0] = !done[0] && !(claimed && !cur_bank);
    assign bank_free[1] = !done[1] && !(claimed && cur_bank);
    assign have_free    = |bank_free;
    assign free_bank    = !bank_free[0];

    assign o_rdy        = |done;
    assign o_rdy_bank   = (&done) ? first : done[1];
    assign o_rdy_len    = o_rdy ? bank_len[o_rdy_bank] : 8'd0;
    assign o_rdy_fcs_ok = o_rdy & bank_fcs[o_rdy_bank];
    assign rel          = i_release && o_rdy;

    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        if (!i_enable) begin
            next_state = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:    next_state = ST_HUNT;
                ST_HUNT:    if (claim) next_state = ST_HDR;
                ST_HDR:     if (load_len) next_state = ST_PAYLOAD;
                            else if (abort) next_state = ST_HUNT;
                ST_PAYLOAD: if (abort || finish) next_state = ST_HUNT;
                default:    next_state = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        push       = 1'b0;
        push_ev    = RX_EV_NONE;
        push_cause = CAUSE_NOBUF;
        wr_en      = 1'b0;
        wr_off     = '0;
        claim      = 1'b0;
        finish     = 1'b0;
        abort      = 1'b0;
        nobuf      = 1'b0;
        load_len   = 1'b0;
        step_cnt   = 1'b0;
        if (i_enable) begin
            case (state)
                ST_HUNT: begin
                    if (strobe && i_dec_ev == DEC_EV_PREAMBLE) begin
                        push    = 1'b1;
                        push_ev = RX_EV_PREAMBLE;
                    end else if (strobe && i_dec_ev == DEC_EV_SFD) begin
                        push = 1'b1;
                        if (have_free) begin
                            claim   = 1'b1;
                            push_ev = RX_EV_SFD;
                        end else begin
                            nobuf      = 1'b1;
                            push_ev    = RX_EV_ERROR;
                            push_cause = CAUSE_NOBUF;
                        end
                    end
                end
                ST_HDR: begin
                    if (tmo_fire) begin
                        abort      = 1'b1;
                        push       = 1'b1;
                        push_ev    = RX_EV_ERROR;
                        push_cause = CAUSE_TIMEOUT;
                    end else if (strobe && i_dec_ev == DEC_EV_PHR) begin
                        push = 1'b1;
                        if (len_bad) begin
                            abort      = 1'b1;
                            push_ev    = RX_EV_ERROR;
                            push_cause = CAUSE_LEN;
                        end else begin
                            load_len = 1'b1;
                            wr_en    = 1'b1;
                            push_ev  = RX_EV_PHR;
                        end
                    end
                end
                ST_PAYLOAD: begin
                    if (tmo_fire) begin
                        abort      = 1'b1;
                        push       = 1'b1;
                        push_ev    = RX_EV_ERROR;
                        push_cause = CAUSE_TIMEOUT;
                    end else if (strobe && i_dec_ev == DEC_EV_BYTE) begin
                        push = 1'b1;
                        if (cnt == len_r) begin
                            abort      = 1'b1;
                            push_ev    = RX_EV_ERROR;
                            push_cause = CAUSE_LEN;
                        end else begin
                            step_cnt = 1'b1;
                            wr_en    = 1'b1;
                            wr_off   = cnt_inc[ADDR_W-1:0];
                            push_ev  = RX_EV_BYTE;
                        end
                    end else if (strobe && i_dec_ev == DEC_EV_COMPLETE) begin
                        push = 1'b1;
                        if (cnt == len_r) begin
                            finish  = 1'b1;
                            push_ev = RX_EV_END;
                        end else begin
                            abort      = 1'b1;
                            push_ev    = RX_EV_ERROR;
                            push_cause = CAUSE_SHORT;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dec_rst     <= 1'b1;
            active      <= 1'b0;
            lost        <= 1'b0;
            buf_w_en    <= 1'b0;
            buf_w_addr  <= '0;
            buf_w_byte  <= '0;
            tmo_cnt     <= '0;
            len_r       <= '0;
            cnt         <= '0;
            claimed     <= 1'b0;
            cur_bank    <= 1'b0;
            first       <= 1'b0;
            done        <= '0;
            bank_fcs    <= '0;
            bank_len[0] <= '0;
            bank_len[1] <= '0;
        end else begin
            dec_rst  <= (next_state == ST_IDLE) || finish || abort || nobuf;
            active   <= i_enable;
            buf_w_en <= wr_en;
            if (wr_en) begin
                buf_w_addr <= {cur_bank, wr_off};
                buf_w_byte <= i_dec_byte;
            end

            if (strobe || !in_frame) tmo_cnt <= '0;
            else                     tmo_cnt <= tmo_cnt + 1'b1;

            if (load_len) begin
                len_r <= len_ext;
                cnt   <= '0;
            end else if (step_cnt) begin
                cnt <= cnt_inc;
            end

            if (!i_enable)     lost <= 1'b0;
            else if (overflow) lost <= 1'b1;

            if (rel) done[o_rdy_bank] <= 1'b0;
            if (claim) begin
                claimed  <= 1'b1;
                cur_bank <= free_bank;
            end
            if (finish) begin
                claimed            <= 1'b0;
                done[cur_bank]     <= 1'b1;
                bank_len[cur_bank] <= len_r[7:0];
                bank_fcs[cur_bank] <= i_dec_fcs_ok;
                // The other bank stays oldest only if it is still held after this cycle.
                first <= (done[~cur_bank] && !(rel && (o_rdy_bank == ~cur_bank))) ? ~cur_bank : cur_bank;
            end
            if (abort || !i_enable) claimed <= 1'b0;
        end
    end

    ev_fifo #(
        .WIDTH (EVQ_W),
        .DEPTH (EVQ_DEPTH)
    ) u_ev_fifo (
        .clk        (clk),
        .reset      (reset),
        .flush      (!i_enable),
        .push       (push),
        .push_data  (pack_ev(push_ev, push_cause)),
        .pop_ready  (i_ev_ready),
        .head_data  (head),
        .head_valid (o_ev_valid),
        .overflow   (overflow)
    );

    assign o_ev         = head[2:0];
    assign o_ev_cause   = head[4:3];
    assign o_ev_lost    = lost;
    assign o_dec_reset  = dec_rst;
    assign o_active     = active;
    assign o_sfd        = in_frame;
    assign o_buf_w_en   = buf_w_en;
    assign o_buf_w_addr = buf_w_addr;
    assign o_buf_w_byte = buf_w_byte;

endmodule
`default_nettype wire

// File: tb/tb_rx_frame_ctrl.sv
`default_nettype none
// Bench for rx_frame_ctrl: directed scenarios then random traffic, all checked
// every cycle against a queue-based reference model of the frame rules.
module tb_rx_frame_ctrl;
    import rx_frame_pkg::*;

    localparam int AW   = 7;
    localparam int QD   = 4;
    localparam int TO   = 16;
    localparam int MAXL = (1 << AW) - 1;

    logic clk = 1'b0;
    logic reset;
    logic i_enable, i_dec_ev_sig, i_dec_fcs_ok, i_ev_ready, i_release;
    logic [2:0] i_dec_ev;
    logic [7:0] i_dec_byte;
    logic o_dec_reset, o_buf_w_en, o_ev_valid, o_ev_lost, o_rdy, o_rdy_bank, o_rdy_fcs_ok, o_sfd, o_active;
    logic [AW:0] o_buf_w_addr;
    logic [7:0] o_buf_w_byte, o_rdy_len;
    logic [2:0] o_ev;
    logic [1:0] o_ev_cause;

    always #5 clk = ~clk;

    rx_frame_ctrl #(.ADDR_W(AW), .EVQ_DEPTH(QD), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .reset(reset), .i_enable(i_enable), .i_dec_ev(i_dec_ev),
        .i_dec_ev_sig(i_dec_ev_sig), .i_dec_byte(i_dec_byte), .i_dec_fcs_ok(i_dec_fcs_ok),
        .o_dec_reset(o_dec_reset), .o_buf_w_en(o_buf_w_en), .o_buf_w_addr(o_buf_w_addr),
        .o_buf_w_byte(o_buf_w_byte), .o_ev(o_ev), .o_ev_cause(o_ev_cause),
        .o_ev_valid(o_ev_valid), .i_ev_ready(i_ev_ready), .o_ev_lost(o_ev_lost),
        .o_rdy(o_rdy), .o_rdy_bank(o_rdy_bank), .o_rdy_len(o_rdy_len),
        .o_rdy_fcs_ok(o_rdy_fcs_ok), .i_release(i_release), .o_sfd(o_sfd), .o_active(o_active)
    );

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Reference model: mode 0 idle, 1 hunt, 2 header, 3 payload.
    int m_mode, m_cyc, m_last, m_len, m_cnt, m_cur;
    bit m_claimed, m_lost, m_pulse;
    int m_q[$];
    int m_done[$];
    int m_blen[2];
    bit m_bfcs[2];
    bit exp_w_en, exp_dec_reset, exp_active, exp_sfd;
    int exp_addr, exp_byte;

    bit en_drv, rdy_drv;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic m_push(input int ev, input int cause);
        if (m_q.size() < QD) m_q.push_back(cause * 8 + ev);
        else m_lost = 1'b1;
    endtask

    task automatic m_err(input int cause);
        m_push(RX_EV_ERROR, cause);
        m_claimed = 1'b0;
        m_pulse   = 1'b1;
        m_mode    = 1;
    endtask

    task automatic m_write(input int off, input int b);
        exp_w_en = 1'b1;
        exp_addr = m_cur * (MAXL + 1) + off;
        exp_byte = b;
    endtask

    function automatic int m_lowest_free();
        for (int b = 0; b < 2; b++) begin
            bit busy;
            busy = m_claimed && (m_cur == b);
            foreach (m_done[k]) if (m_done[k] == b) busy = 1'b1;
            if (!busy) return b;
        end
        return -1;
    endfunction

    task automatic model_step();
        bit rel_ok;
        int nb;
        m_cyc++;
        exp_w_en = 1'b0;
        m_pulse  = 1'b0;
        if (reset) begin
            m_mode = 0; m_claimed = 0; m_lost = 0; m_len = 0; m_cnt = 0; m_last = m_cyc;
            m_q.delete(); m_done.delete();
            exp_dec_reset = 1'b1; exp_active = 1'b0; exp_sfd = 1'b0;
            return;
        end
        rel_ok = i_release && (m_done.size() > 0);
        if (i_ev_ready && m_q.size() > 0) void'(m_q.pop_front());
        if (!i_enable) begin
            m_mode = 0; m_claimed = 0; m_lost = 0;
            m_q.delete();
        end else if (m_mode == 0) begin
            m_mode = 1;
        end else if (m_mode >= 2 && !i_dec_ev_sig && (m_cyc - m_last) == TO) begin
            m_err(CAUSE_TIMEOUT);
        end else if (i_dec_ev_sig) begin
            m_last = m_cyc;
            case (m_mode)
                1: if (i_dec_ev == DEC_EV_PREAMBLE) m_push(RX_EV_PREAMBLE, 0);
                   else if (i_dec_ev == DEC_EV_SFD) begin
                       nb = m_lowest_free();
                       if (nb < 0) begin
                           m_push(RX_EV_ERROR, CAUSE_NOBUF);
                           m_pulse = 1'b1;
                       end else begin
                           m_claimed = 1'b1; m_cur = nb; m_mode = 2;
                           m_push(RX_EV_SFD, 0);
                       end
                   end
                2: if (i_dec_ev == DEC_EV_PHR) begin
                       if (i_dec_byte == 0 || int'(i_dec_byte) > MAXL) m_err(CAUSE_LEN);
                       else begin
                           m_write(0, i_dec_byte);
                           m_len = i_dec_byte; m_cnt = 0; m_mode = 3;
                           m_push(RX_EV_PHR, 0);
                       end
                   end
                3: if (i_dec_ev == DEC_EV_BYTE) begin
                       if (m_cnt == m_len) m_err(CAUSE_LEN);
                       else begin
                           m_cnt++;
                           m_write(m_cnt, i_dec_byte);
                           m_push(RX_EV_BYTE, 0);
                       end
                   end else if (i_dec_ev == DEC_EV_COMPLETE) begin
                       if (m_cnt == m_len) begin
                           m_done.push_back(m_cur);
                           m_blen[m_cur] = m_len; m_bfcs[m_cur] = i_dec_fcs_ok;
                           m_claimed = 1'b0; m_pulse = 1'b1; m_mode = 1;
                           m_push(RX_EV_END, 0);
                       end else m_err(CAUSE_SHORT);
                   end
                default: ;
            endcase
        end
        if (rel_ok) void'(m_done.pop_front());
        exp_dec_reset = (m_mode == 0) || m_pulse;
        exp_active    = i_enable;
        exp_sfd       = (m_mode >= 2);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("dec_reset", o_dec_reset, exp_dec_reset);
            chk("active", o_active, exp_active);
            chk("sfd", o_sfd, exp_sfd);
            chk("buf_w_en", o_buf_w_en, exp_w_en);
            if (exp_w_en) begin
                chk("buf_w_addr", o_buf_w_addr, exp_addr);
                chk("buf_w_byte", o_buf_w_byte, exp_byte);
            end
            chk("ev_valid", o_ev_valid, m_q.size() > 0);
            if (m_q.size() > 0) begin
                chk("ev", o_ev, m_q[0] % 8);
                if (m_q[0] % 8 == RX_EV_ERROR) chk("ev_cause", o_ev_cause, m_q[0] / 8);
            end
            chk("ev_lost", o_ev_lost, m_lost);
            chk("rdy", o_rdy, m_done.size() > 0);
            if (m_done.size() > 0) begin
                chk("rdy_bank", o_rdy_bank, m_done[0]);
                chk("rdy_len", o_rdy_len, m_blen[m_done[0]]);
                chk("rdy_fcs_ok", o_rdy_fcs_ok, m_bfcs[m_done[0]]);
            end
        end
    end

    task automatic drive(input bit sig, input int e, input int b, input bit fcs, input bit rel);
        i_enable     = en_drv;
        i_ev_ready   = rdy_drv;
        i_dec_ev_sig = sig;
        i_dec_ev     = 3'(e);
        i_dec_byte   = 8'(b);
        i_dec_fcs_ok = fcs;
        i_release    = rel;
        @(posedge clk);
        #1;
        model_step();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(0, 0, 0, 0, 0);
    endtask

    task automatic strobe(input int e, input int b = 0, input bit fcs = 0);
        drive(1, e, b, fcs, 0);
    endtask

    initial begin
        reset = 1'b1; en_drv = 0; rdy_drv = 1; chk_en = 1'b1;
        idle(3);
        chk("reset_dec_reset", o_dec_reset, 1);
        chk("reset_ev_valid", o_ev_valid, 0);
        chk("reset_rdy", o_rdy, 0);
        reset = 1'b0;
        en_drv = 1;
        idle(2);

        // Nominal frame
        strobe(DEC_EV_PREAMBLE);
        strobe(DEC_EV_SFD);
        strobe(DEC_EV_PHR, 3);
        chk("lit_phr_write", {o_buf_w_en, o_buf_w_addr, o_buf_w_byte}, {1'b1, 8'h00, 8'h03});
        strobe(DEC_EV_BYTE, 8'hA1);
        strobe(DEC_EV_BYTE, 8'hA2);
        strobe(DEC_EV_BYTE, 8'hA3);
        chk("lit_byte3_write", {o_buf_w_addr, o_buf_w_byte}, {8'h03, 8'hA3});
        strobe(DEC_EV_COMPLETE, 0, 1);
        chk("lit_rdy", {o_rdy, o_rdy_bank, o_rdy_len, o_rdy_fcs_ok, o_sfd}, {1'b1, 1'b0, 8'd3, 1'b1, 1'b0});
        idle(8);

        // Second frame into bank 1, third SFD has no bank
        strobe(DEC_EV_SFD);
        strobe(DEC_EV_PHR, 1);
        strobe(DEC_EV_BYTE, 8'h55);
        strobe(DEC_EV_COMPLETE, 0, 0);
        idle(2);
        strobe(DEC_EV_SFD);
        chk("lit_nobuf_reset", o_dec_reset, 1);
        idle(1);
        drive(0, 0, 0, 0, 1);
        chk("lit_release_bank", {o_rdy, o_rdy_bank}, 2'b11);
        idle(4);

        // Length overrun, short frame, timeout
        strobe(DEC_EV_SFD);
        strobe(DEC_EV_PHR, 2);
        for (int k = 0; k < 3; k++) strobe(DEC_EV_BYTE, 8'h10 + k);
        idle(2);
        strobe(DEC_EV_SFD);
        strobe(DEC_EV_PHR, 4);
        strobe(DEC_EV_BYTE, 1);
        strobe(DEC_EV_BYTE, 2);
        strobe(DEC_EV_COMPLETE, 0, 1);
        idle(2);
        strobe(DEC_EV_SFD);
        strobe(DEC_EV_PHR, 0);
        strobe(DEC_EV_SFD);
        strobe(DEC_EV_PHR, 200);
        strobe(DEC_EV_SFD);
        strobe(DEC_EV_PHR, 5);
        idle(TO - 1);
        chk("lit_before_timeout", o_sfd, 1);
        idle(1);
        chk("lit_timeout", {o_sfd, o_dec_reset, o_ev_valid, o_ev, o_ev_cause},
            {1'b0, 1'b1, 1'b1, RX_EV_ERROR, CAUSE_TIMEOUT});
        idle(3);
        drive(0, 0, 0, 0, 1);
        idle(2);

        // Backpressure: six events into a four-entry queue
        rdy_drv = 0;
        strobe(DEC_EV_PREAMBLE);
        strobe(DEC_EV_SFD);
        strobe(DEC_EV_PHR, 2);
        strobe(DEC_EV_BYTE, 8'h77);
        strobe(DEC_EV_BYTE, 8'h78);
        strobe(DEC_EV_COMPLETE, 0, 1);
        chk("lit_lost", {o_ev_lost, o_ev}, {1'b1, RX_EV_PREAMBLE});
        rdy_drv = 1;
        idle(6);
        en_drv = 0; idle(1);
        en_drv = 1; idle(1);
        rdy_drv = 0;
        for (int k = 0; k < QD; k++) strobe(DEC_EV_PREAMBLE);
        rdy_drv = 1;
        strobe(DEC_EV_PREAMBLE);
        chk("lit_push_pop_full", o_ev_lost, 0);
        idle(6);

        // Enable dropped mid-payload
        strobe(DEC_EV_SFD);
        strobe(DEC_EV_PHR, 3);
        strobe(DEC_EV_BYTE, 8'h99);
        en_drv = 0;
        idle(1);
        chk("lit_disable", {o_active, o_sfd, o_ev_valid, o_rdy, o_rdy_bank}, {1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
        en_drv = 1;
        idle(1);
        strobe(DEC_EV_SFD);
        strobe(DEC_EV_PHR, 1);
        idle(2);

        // Random traffic
        for (int n = 0; n < 4000; n++) begin
            int r, e, b;
            en_drv  = ($urandom_range(0, 99) >= 2);
            rdy_drv = ($urandom_range(0, 9) < 7);
            r = $urandom_range(0, 15);
            case (r)
                0:                   e = DEC_EV_NONE;
                1:                   e = DEC_EV_PREAMBLE;
                2, 3:                e = DEC_EV_SFD;
                4, 5:                e = DEC_EV_PHR;
                6, 7, 8, 9, 10, 11:  e = DEC_EV_BYTE;
                12, 13:              e = DEC_EV_COMPLETE;
                14:                  e = 6;
                default:             e = 7;
            endcase
            b = (e == DEC_EV_PHR && $urandom_range(0, 3) != 0) ? $urandom_range(0, 5) : $urandom_range(0, 255);
            if ($urandom_range(0, 79) == 0) idle(TO + 2);
            drive($urandom_range(0, 9) < 4, e, b, $urandom_range(0, 1), $urandom_range(0, 19) == 0);
        end

        idle(2);
        @(negedge clk);
        #1;
        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
